// File: rtl/vga_timing_cfg_ctrl_pkg.sv
// Shared types for the VGA timing configuration controller: field widths,
// the eight-field timing record, mode presets and controller states.
package vga_pkg;

  localparam int CFG_HW = 11;
  localparam int CFG_VW = 10;

  typedef enum logic [1:0] {
    MODE_640X480  = 2'd0,
    MODE_800X600  = 2'd1,
    MODE_1024X768 = 2'd2,
    MODE_ILLEGAL  = 2'd3
  } mode_e;

  typedef struct packed {
    logic [CFG_HW-1:0] hd;
    logic [CFG_HW-1:0] hf;
    logic [CFG_HW-1:0] hr;
    logic [CFG_HW-1:0] hb;
    logic [CFG_VW-1:0] vd;
    logic [CFG_VW-1:0] vf;
    logic [CFG_VW-1:0] vr;
    logic [CFG_VW-1:0] vb;
  } timing_cfg_t;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT_FRAME,
    ST_APPLY
  } state_e;

  // Anything that is not mode 1 or 2 falls back to 640x480.
  function automatic timing_cfg_t preset(input logic [1:0] mode);
    case (mode)
      2'd1: return timing_cfg_t'{CFG_HW'(800), CFG_HW'(40), CFG_HW'(128), CFG_HW'(88),
                                 CFG_VW'(600), CFG_VW'(1), CFG_VW'(4), CFG_VW'(23)};
      2'd2: return timing_cfg_t'{CFG_HW'(1024), CFG_HW'(24), CFG_HW'(136), CFG_HW'(160),
                                 CFG_VW'(768), CFG_VW'(3), CFG_VW'(6), CFG_VW'(29)};
      default: return timing_cfg_t'{CFG_HW'(640), CFG_HW'(16), CFG_HW'(96), CFG_HW'(48),
                                    CFG_VW'(480), CFG_VW'(10), CFG_VW'(2), CFG_VW'(33)};
    endcase
  endfunction

endpackage

// File: rtl/vga_timing_cfg_ctrl_check.sv
// Combinational sanity check of a timing set: nonzero display/sync widths and
// line/frame totals that still fit the generator counters.
module vga_cfg_check
  import vga_pkg::*;
(
  input  timing_cfg_t         cfg_i,
  output logic                ok_o,
  output logic [CFG_HW+1:0]   htot_o,
  output logic [CFG_VW+1:0]   vtot_o
);

  localparam logic [CFG_HW+1:0] HMAX = (CFG_HW+2)'(2**CFG_HW);
  localparam logic [CFG_VW+1:0] VMAX = (CFG_VW+2)'(2**CFG_VW);

  // Two guard bits so the four-way sum can never wrap.
  assign htot_o = (CFG_HW+2)'(cfg_i.hd) + (CFG_HW+2)'(cfg_i.hf)
                + (CFG_HW+2)'(cfg_i.hr) + (CFG_HW+2)'(cfg_i.hb);
  assign vtot_o = (CFG_VW+2)'(cfg_i.vd) + (CFG_VW+2)'(cfg_i.vf)
                + (CFG_VW+2)'(cfg_i.vr) + (CFG_VW+2)'(cfg_i.vb);

  assign ok_o = (cfg_i.hd != '0) && (cfg_i.hr != '0) &&
                (cfg_i.vd != '0) && (cfg_i.vr != '0) &&
                (htot_o <= HMAX) && (vtot_o <= VMAX);

endmodule

// File: rtl/vga_timing_cfg_ctrl.sv
// Shadow/active timing register pair for the VGA generator; a validated commit
// is applied on the last pixel of the frame and flagged with one write-enable tick.
module vga_timing_cfg_ctrl
  import vga_pkg::*;
#(
  parameter int HW           = CFG_HW,
  parameter int VW           = CFG_VW,
  parameter int DEFAULT_MODE = 0
) (
  input  logic          clk_i,
  input  logic          arst_ni,
  input  logic          tick_i,
  input  logic [HW-1:0] hcount_i,
  input  logic [VW-1:0] vcount_i,
  input  logic          cfg_valid_i,
  output logic          cfg_ready_o,
  input  logic [2:0]    cfg_addr_i,
  input  logic [HW-1:0] cfg_wdata_i,
  input  logic          mode_load_i,
  input  logic [1:0]    mode_i,
  input  logic          commit_i,
  output logic          busy_o,
  output logic          cfg_err_o,
  output logic [HW-1:0] hd_o,
  output logic [HW-1:0] hf_o,
  output logic [HW-1:0] hr_o,
  output logic [HW-1:0] hb_o,
  output logic [VW-1:0] vd_o,
  output logic [VW-1:0] vf_o,
  output logic [VW-1:0] vr_o,
  output logic [VW-1:0] vb_o,
  output logic          we_o
);

  state_e            state_q;
  logic              we_q, err_q, pend_q;
  timing_cfg_t       shd_q, shd_d, act_q;
  logic              shd_ok, act_ok;
  logic [CFG_HW+1:0] shd_htot, act_htot;
  logic [CFG_VW+1:0] shd_vtot, act_vtot;
  logic              idle_open, load_ok, boundary;
  logic              unused_sig;

  vga_cfg_check u_chk_shadow (.cfg_i(shd_q), .ok_o(shd_ok), .htot_o(shd_htot), .vtot_o(shd_vtot));
  vga_cfg_check u_chk_active (.cfg_i(act_q), .ok_o(act_ok), .htot_o(act_htot), .vtot_o(act_vtot));

  assign unused_sig = ^{shd_htot, shd_vtot};

  // Shadow is closed while a validation is pending so the checked set is what lands.
  assign idle_open = (state_q == ST_IDLE) && !pend_q;
  assign load_ok   = mode_load_i && (mode_e'(mode_i) != MODE_ILLEGAL);

  assign boundary = tick_i && act_ok &&
                    ((CFG_HW+2)'(hcount_i) == act_htot - (CFG_HW+2)'(1)) &&
                    ((CFG_VW+2)'(vcount_i) == act_vtot - (CFG_VW+2)'(1));

  always_comb begin
    shd_d = shd_q;
    if (idle_open) begin
      if (mode_load_i) begin
        if (load_ok) shd_d = preset(mode_i);
      end else if (cfg_valid_i) begin
        case (cfg_addr_i)
          3'd0: shd_d.hd = cfg_wdata_i;
          3'd1: shd_d.hf = cfg_wdata_i;
          3'd2: shd_d.hr = cfg_wdata_i;
          3'd3: shd_d.hb = cfg_wdata_i;
          3'd4: shd_d.vd = cfg_wdata_i[VW-1:0];
          3'd5: shd_d.vf = cfg_wdata_i[VW-1:0];
          3'd6: shd_d.vr = cfg_wdata_i[VW-1:0];
          3'd7: shd_d.vb = cfg_wdata_i[VW-1:0];
          default: shd_d = shd_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= ST_INIT;
      we_q    <= 1'b1;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      shd_q   <= preset(2'(DEFAULT_MODE));
      act_q   <= preset(2'(DEFAULT_MODE));
    end else begin
      shd_q  <= shd_d;
      pend_q <= 1'b0;
      case (state_q)
        ST_INIT: begin
          if (tick_i) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (pend_q) begin
            if (shd_ok) begin
              err_q   <= 1'b0;
              state_q <= ST_WAIT_FRAME;
            end else begin
              err_q <= 1'b1;
            end
          end else begin
            pend_q <= commit_i;
            if (mode_load_i && !load_ok) err_q <= 1'b1;
          end
        end
        ST_WAIT_FRAME: begin
          if (boundary) begin
            act_q   <= shd_q;
            we_q    <= 1'b1;
            state_q <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          if (tick_i) begin
            we_q    <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign cfg_ready_o = idle_open;
  assign busy_o      = (state_q != ST_IDLE);
  assign cfg_err_o   = err_q;
  assign we_o        = we_q;
  assign hd_o = act_q.hd;
  assign hf_o = act_q.hf;
  assign hr_o = act_q.hr;
  assign hb_o = act_q.hb;
  assign vd_o = act_q.vd;
  assign vf_o = act_q.vf;
  assign vr_o = act_q.vr;
  assign vb_o = act_q.vb;

endmodule
